// File: rtl/axi4lite_pkg.sv
// Shared types for the AXI4-Lite to register-demux memory bridge:
// response codes, write/read FSM state encodings and index-width helper.
package axi4lite_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } axi_resp_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ACCESS,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ACCESS,
        R_RESP
    } rd_state_t;

    // Width of the register index; never narrower than one bit.
    function automatic int reg_index_width(input int register_n);
        return (register_n > 1) ? $clog2(register_n) : 1;
    endfunction

endpackage

// File: rtl/axi4lite_mem_bridge.sv
// AXI4-Lite slave front end driving a single-cycle register memory interface.
// Independent write and read FSMs; each accepted access makes at most one
// mem_*Select pulse and exactly one response.
// Optional feature macro: AXIL_BRIDGE_SLVERR_EN -- out-of-range accesses answer
// SLVERR instead of OKAY (they never reach the memory interface either way).
module axi4lite_mem_bridge
    import axi4lite_pkg::*;
#(
    parameter int REGISTER_N         = 16,
    parameter int REG_DATA_WIDTH     = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 8
) (
    input  logic                                    S_AXI_ACLK,
    input  logic                                    S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]           S_AXI_AWADDR,
    input  logic [2:0]                              S_AXI_AWPROT,
    input  logic                                    S_AXI_AWVALID,
    output logic                                    S_AXI_AWREADY,
    input  logic [REG_DATA_WIDTH-1:0]               S_AXI_WDATA,
    input  logic [REG_DATA_WIDTH/8-1:0]             S_AXI_WSTRB,
    input  logic                                    S_AXI_WVALID,
    output logic                                    S_AXI_WREADY,
    output logic [1:0]                              S_AXI_BRESP,
    output logic                                    S_AXI_BVALID,
    input  logic                                    S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]           S_AXI_ARADDR,
    input  logic [2:0]                              S_AXI_ARPROT,
    input  logic                                    S_AXI_ARVALID,
    output logic                                    S_AXI_ARREADY,
    output logic [REG_DATA_WIDTH-1:0]               S_AXI_RDATA,
    output logic [1:0]                              S_AXI_RRESP,
    output logic                                    S_AXI_RVALID,
    input  logic                                    S_AXI_RREADY,
    output logic                                    mem_wrSelect,
    output logic [reg_index_width(REGISTER_N)-1:0]  mem_wrAddr,
    output logic [REG_DATA_WIDTH-1:0]               mem_wrdin,
    output logic [REG_DATA_WIDTH/8-1:0]             mem_wrByteStrobe,
    output logic                                    mem_rdSelect,
    output logic                                    mem_rdStrobe,
    output logic [reg_index_width(REGISTER_N)-1:0]  mem_rdAddr,
    input  logic [REG_DATA_WIDTH-1:0]               mem_rddout
);

    localparam int STRB_W     = REG_DATA_WIDTH / 8;
    localparam int IDX_W      = reg_index_width(REGISTER_N);
    localparam int BYTE_SHIFT = $clog2(STRB_W);
    localparam logic [C_S_AXI_ADDR_WIDTH-1:0] REG_LIMIT = C_S_AXI_ADDR_WIDTH'(REGISTER_N);

`ifdef AXIL_BRIDGE_SLVERR_EN
    localparam axi_resp_t OOR_RESP = RESP_SLVERR;
`else
    localparam axi_resp_t OOR_RESP = RESP_OKAY;
`endif

    logic                           r_rst_done;
    wr_state_t                      r_wr_state;
    wr_state_t                      w_wr_state_next;
    rd_state_t                      r_rd_state;
    rd_state_t                      w_rd_state_next;
    logic                           r_aw_held;
    logic                           r_w_held;
    logic [C_S_AXI_ADDR_WIDTH-1:0]  r_awaddr;
    logic [REG_DATA_WIDTH-1:0]      r_wdata;
    logic [STRB_W-1:0]              r_wstrb;
    axi_resp_t                      r_bresp;
    logic [C_S_AXI_ADDR_WIDTH-1:0]  r_araddr;
    logic [REG_DATA_WIDTH-1:0]      r_rdata;
    axi_resp_t                      r_rresp;

    logic [C_S_AXI_ADDR_WIDTH-1:0]  w_widx;
    logic [C_S_AXI_ADDR_WIDTH-1:0]  w_ridx;
    logic                           w_wr_in_range;
    logic                           w_rd_in_range;
    logic                           w_aw_hs;
    logic                           w_w_hs;
    logic                           w_ar_hs;
    logic                           w_unused;

    // PROT carries no meaning for a flat register space.
    assign w_unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT};

    // Full-width index compare also rejects any set address bit above the index field.
    assign w_widx        = r_awaddr >> BYTE_SHIFT;
    assign w_ridx        = r_araddr >> BYTE_SHIFT;
    assign w_wr_in_range = (w_widx < REG_LIMIT);
    assign w_rd_in_range = (w_ridx < REG_LIMIT);

    // Readies are held low until the first edge after reset release.
    assign S_AXI_AWREADY = r_rst_done && (r_wr_state == W_IDLE) && !r_aw_held;
    assign S_AXI_WREADY  = r_rst_done && (r_wr_state == W_IDLE) && !r_w_held;
    assign S_AXI_ARREADY = r_rst_done && (r_rd_state == R_IDLE);
    assign w_aw_hs       = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_w_hs        = S_AXI_WVALID  && S_AXI_WREADY;
    assign w_ar_hs       = S_AXI_ARVALID && S_AXI_ARREADY;

    assign S_AXI_BVALID  = (r_wr_state == W_RESP);
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_RVALID  = (r_rd_state == R_RESP);
    assign S_AXI_RRESP   = r_rresp;
    assign S_AXI_RDATA   = r_rdata;

    // Memory side: selects live only in the single access cycle, and only in range.
    assign mem_wrSelect     = (r_wr_state == W_ACCESS) && w_wr_in_range;
    assign mem_wrByteStrobe = mem_wrSelect ? r_wstrb : '0;
    assign mem_wrAddr       = w_widx[IDX_W-1:0];
    assign mem_wrdin        = r_wdata;
    assign mem_rdSelect     = (r_rd_state == R_ACCESS) && w_rd_in_range;
    assign mem_rdStrobe     = mem_rdSelect;
    assign mem_rdAddr       = w_ridx[IDX_W-1:0];

    // Registered reset-release flag gating the ready outputs.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) r_rst_done <= 1'b0;
        else                r_rst_done <= 1'b1;
    end

    // Write and read FSM state registers.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_wr_state <= W_IDLE;
            r_rd_state <= R_IDLE;
        end else begin
            r_wr_state <= w_wr_state_next;
            r_rd_state <= w_rd_state_next;
        end
    end

    // Write next state: AW and W may arrive in either order or together.
    always_comb begin
        w_wr_state_next = r_wr_state;
        case (r_wr_state)
            W_IDLE:   if ((r_aw_held || w_aw_hs) && (r_w_held || w_w_hs)) w_wr_state_next = W_ACCESS;
            W_ACCESS: w_wr_state_next = W_RESP;
            W_RESP:   if (S_AXI_BREADY) w_wr_state_next = W_IDLE;
            default:  w_wr_state_next = W_IDLE;
        endcase
    end

    // Read next state: one-cycle access between address and response.
    always_comb begin
        w_rd_state_next = r_rd_state;
        case (r_rd_state)
            R_IDLE:   if (w_ar_hs) w_rd_state_next = R_ACCESS;
            R_ACCESS: w_rd_state_next = R_RESP;
            R_RESP:   if (S_AXI_RREADY) w_rd_state_next = R_IDLE;
            default:  w_rd_state_next = R_IDLE;
        endcase
    end

    // Write channel capture and response code.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bresp   <= RESP_OKAY;
        end else begin
            if (w_aw_hs) begin
                r_awaddr  <= S_AXI_AWADDR;
                r_aw_held <= 1'b1;
            end
            if (w_w_hs) begin
                r_wdata  <= S_AXI_WDATA;
                r_wstrb  <= S_AXI_WSTRB;
                r_w_held <= 1'b1;
            end
            // Both halves consumed once the access is launched.
            if ((r_wr_state == W_IDLE) && (w_wr_state_next == W_ACCESS)) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
            end
            if (r_wr_state == W_ACCESS)
                r_bresp <= w_wr_in_range ? RESP_OKAY : OOR_RESP;
        end
    end

    // Read address capture and registered read data / response.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_araddr <= '0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else begin
            if (w_ar_hs)
                r_araddr <= S_AXI_ARADDR;
            if (r_rd_state == R_ACCESS) begin
                r_rdata <= w_rd_in_range ? mem_rddout : '0;
                r_rresp <= w_rd_in_range ? RESP_OKAY : OOR_RESP;
            end
        end
    end

endmodule

// File: tb/tb_axi4lite_mem_bridge.sv
// Self-checking bench for axi4lite_mem_bridge (16 x 32-bit registers, 8-bit
// addresses). Expected memory pulses and bus responses are queued when stimulus
// is issued and popped by a negedge monitor when the DUT produces them.
module tb_axi4lite_mem_bridge;

`ifdef AXIL_BRIDGE_SLVERR_EN
    localparam logic [1:0] OOR_RESP = 2'b10;
`else
    localparam logic [1:0] OOR_RESP = 2'b00;
`endif

    typedef struct packed {
        logic [3:0]  idx;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  S_AXI_AWADDR = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [7:0]  S_AXI_ARADDR = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;
    logic        mem_wrSelect;
    logic [3:0]  mem_wrAddr;
    logic [31:0] mem_wrdin;
    logic [3:0]  mem_wrByteStrobe;
    logic        mem_rdSelect;
    logic        mem_rdStrobe;
    logic [3:0]  mem_rdAddr;
    logic [31:0] mem_rddout;

    logic [31:0] rd_regs [16];
    wr_exp_t     exp_wr[$];
    logic [3:0]  exp_rd[$];
    logic [1:0]  exp_b[$];
    logic [33:0] exp_r[$];
    int          n_checks = 0;
    int          n_fail = 0;

    assign mem_rddout = rd_regs[mem_rdAddr];

    always #5 clk = ~clk;

    axi4lite_mem_bridge #(
        .REGISTER_N(16), .REG_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(8)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(3'b000),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(3'b000),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .mem_wrSelect(mem_wrSelect), .mem_wrAddr(mem_wrAddr), .mem_wrdin(mem_wrdin),
        .mem_wrByteStrobe(mem_wrByteStrobe), .mem_rdSelect(mem_rdSelect),
        .mem_rdStrobe(mem_rdStrobe), .mem_rdAddr(mem_rdAddr), .mem_rddout(mem_rddout)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void expect_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        if (a < 8'h40) begin
            exp_wr.push_back('{idx: a[5:2], data: d, strb: s});
            exp_b.push_back(2'b00);
        end else begin
            exp_b.push_back(OOR_RESP);
        end
    endfunction

    function automatic void expect_read(input logic [7:0] a);
        if (a < 8'h40) begin
            exp_rd.push_back(a[5:2]);
            exp_r.push_back({2'b00, rd_regs[a[5:2]]});
        end else begin
            exp_r.push_back({OOR_RESP, 32'h0});
        end
    endfunction

    task automatic send_aw(input logic [7:0] a);
        int n = 0;
        S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1;
        do begin @(negedge clk); n++; end while (!S_AXI_AWREADY && n < 50);
        check("aw_accepted", S_AXI_AWREADY, 1'b1);
        @(posedge clk); #1; S_AXI_AWVALID = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1;
        do begin @(negedge clk); n++; end while (!S_AXI_WREADY && n < 50);
        check("w_accepted", S_AXI_WREADY, 1'b1);
        @(posedge clk); #1; S_AXI_WVALID = 1'b0;
    endtask

    task automatic send_ar(input logic [7:0] a);
        int n = 0;
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
        do begin @(negedge clk); n++; end while (!S_AXI_ARREADY && n < 50);
        check("ar_accepted", S_AXI_ARREADY, 1'b1);
        @(posedge clk); #1; S_AXI_ARVALID = 1'b0;
    endtask

    // Waits for BVALID, keeps BREADY low for `hold` sampled cycles, then accepts.
    task automatic recv_b(input int hold);
        int n = 0;
        @(posedge clk); #1; S_AXI_BREADY = (hold == 0);
        do begin @(negedge clk); n++; end while (!S_AXI_BVALID && n < 50);
        check("b_valid_seen", S_AXI_BVALID, 1'b1);
        for (int i = 1; i < hold; i++) begin
            @(negedge clk); check("b_valid_held", S_AXI_BVALID, 1'b1);
        end
        if (hold != 0) begin @(posedge clk); #1; S_AXI_BREADY = 1'b1; @(negedge clk); end
        @(posedge clk); #1; S_AXI_BREADY = 1'b0;
    endtask

    task automatic recv_r(input int hold);
        int n = 0;
        @(posedge clk); #1; S_AXI_RREADY = (hold == 0);
        do begin @(negedge clk); n++; end while (!S_AXI_RVALID && n < 50);
        check("r_valid_seen", S_AXI_RVALID, 1'b1);
        for (int i = 1; i < hold; i++) begin
            @(negedge clk); check("r_valid_held", S_AXI_RVALID, 1'b1);
        end
        if (hold != 0) begin @(posedge clk); #1; S_AXI_RREADY = 1'b1; @(negedge clk); end
        @(posedge clk); #1; S_AXI_RREADY = 1'b0;
    endtask

    // Scoreboard monitor: every pulse/handshake must match the head of its queue.
    always @(negedge clk) begin
        wr_exp_t     w;
        logic [3:0]  ri;
        logic [1:0]  br;
        logic [33:0] rr;
        if (rst_n) begin
            if (mem_wrSelect) begin
                check("wr_pulse_expected", exp_wr.size() != 0, 1'b1);
                if (exp_wr.size() != 0) begin
                    w = exp_wr.pop_front();
                    $display("mem write idx=%0d data=%08h strb=%h", mem_wrAddr, mem_wrdin, mem_wrByteStrobe);
                    check("wr_addr", mem_wrAddr, w.idx);
                    check("wr_data", mem_wrdin, w.data);
                    check("wr_strb", mem_wrByteStrobe, w.strb);
                end
            end else begin
                check("wr_strb_idle", mem_wrByteStrobe, 4'h0);
            end
            check("rd_strobe_eq_select", mem_rdStrobe, mem_rdSelect);
            if (mem_rdSelect) begin
                check("rd_pulse_expected", exp_rd.size() != 0, 1'b1);
                if (exp_rd.size() != 0) begin
                    ri = exp_rd.pop_front();
                    $display("mem read idx=%0d", mem_rdAddr);
                    check("rd_addr", mem_rdAddr, ri);
                end
            end
            if (S_AXI_BVALID && S_AXI_BREADY) begin
                check("b_expected", exp_b.size() != 0, 1'b1);
                if (exp_b.size() != 0) begin
                    br = exp_b.pop_front();
                    $display("B response resp=%0d", S_AXI_BRESP);
                    check("bresp", S_AXI_BRESP, br);
                end
            end
            if (S_AXI_RVALID && S_AXI_RREADY) begin
                check("r_expected", exp_r.size() != 0, 1'b1);
                if (exp_r.size() != 0) begin
                    rr = exp_r.pop_front();
                    $display("R response resp=%0d data=%08h", S_AXI_RRESP, S_AXI_RDATA);
                    check("rresp", S_AXI_RRESP, rr[33:32]);
                    check("rdata", S_AXI_RDATA, rr[31:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) rd_regs[i] = 32'hC0DE0000 | i;
        rd_regs[15] = 32'h12345678;
        rd_regs[1]  = 32'hCAFE0001;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_awready", S_AXI_AWREADY, 1'b0);
        check("rst_wready", S_AXI_WREADY, 1'b0);
        check("rst_arready", S_AXI_ARREADY, 1'b0);
        check("rst_bvalid", S_AXI_BVALID, 1'b0);
        check("rst_rvalid", S_AXI_RVALID, 1'b0);
        check("rst_wrsel", mem_wrSelect, 1'b0);
        check("rst_rdsel", mem_rdSelect, 1'b0);
        check("rst_rdstrobe", mem_rdStrobe, 1'b0);
        check("rst_wrstrb", mem_wrByteStrobe, 4'h0);
        check("rst_rdata", S_AXI_RDATA, 32'h0);
        check("rst_bresp", S_AXI_BRESP, 2'b00);
        check("rst_rresp", S_AXI_RRESP, 2'b00);
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk); check("rel_awready_early", S_AXI_AWREADY, 1'b0);
        @(negedge clk);
        check("rel_awready", S_AXI_AWREADY, 1'b1);
        check("rel_wready", S_AXI_WREADY, 1'b1);
        check("rel_arready", S_AXI_ARREADY, 1'b1);

        // 1: AW and W together
        @(posedge clk); #1;
        expect_write(8'h08, 32'hDEADBEEF, 4'hF);
        fork send_aw(8'h08); send_w(32'hDEADBEEF, 4'hF); join
        @(negedge clk);
        check("t1_wrsel", mem_wrSelect, 1'b1);
        check("t1_bvalid_early", S_AXI_BVALID, 1'b0);
        @(negedge clk);
        check("t1_bvalid", S_AXI_BVALID, 1'b1);
        check("t1_wrsel_single", mem_wrSelect, 1'b0);
        recv_b(0);

        // 2: W three cycles before AW, BREADY held off
        send_w(32'hA5A5_1234, 4'h3);
        repeat (3) @(posedge clk); #1;
        expect_write(8'h0C, 32'hA5A5_1234, 4'h3);
        send_aw(8'h0C);
        recv_b(4);

        // 3: in-range read at the top index
        expect_read(8'h3C);
        send_ar(8'h3C);
        @(negedge clk);
        check("t3_rdsel", mem_rdSelect, 1'b1);
        @(negedge clk);
        check("t3_rvalid", S_AXI_RVALID, 1'b1);
        recv_r(2);

        // 4: out-of-range read and write
        expect_read(8'h40);
        send_ar(8'h40);
        recv_r(0);
        expect_write(8'h80, 32'h0BAD_0BAD, 4'hF);
        fork send_aw(8'h80); send_w(32'h0BAD_0BAD, 4'hF); join
        recv_b(1);

        // 5: concurrent write and read to the same index
        expect_write(8'h04, 32'h1357_9BDF, 4'hC);
        expect_read(8'h04);
        fork send_aw(8'h04); send_w(32'h1357_9BDF, 4'hC); send_ar(8'h04); join
        @(negedge clk);
        check("t5_wrsel", mem_wrSelect, 1'b1);
        check("t5_rdsel", mem_rdSelect, 1'b1);
        fork recv_b(2); recv_r(0); join

        // 6: reset during W_RESP drops the response
        expect_write(8'h10, 32'h7777_0000, 4'h1);
        fork send_aw(8'h10); send_w(32'h7777_0000, 4'h1); join
        repeat (2) @(negedge clk);
        check("t6_bvalid_before_rst", S_AXI_BVALID, 1'b1);
        #2; rst_n = 1'b0;
        #1;
        check("t6_bvalid_in_rst", S_AXI_BVALID, 1'b0);
        check("t6_awready_in_rst", S_AXI_AWREADY, 1'b0);
        exp_b.delete();
        repeat (2) @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk); check("t6_awready_early", S_AXI_AWREADY, 1'b0);
        @(negedge clk);
        check("t6_awready", S_AXI_AWREADY, 1'b1);
        check("t6_arready", S_AXI_ARREADY, 1'b1);
        @(posedge clk); #1;
        expect_write(8'h14, 32'h2468_ACE0, 4'hF);
        fork send_aw(8'h14); send_w(32'h2468_ACE0, 4'hF); join
        recv_b(0);

        repeat (4) @(negedge clk);
        check("end_wr_q_empty", exp_wr.size(), 0);
        check("end_rd_q_empty", exp_rd.size(), 0);
        check("end_b_q_empty", exp_b.size(), 0);
        check("end_r_q_empty", exp_r.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
